// File: rtl/program_loader_if.sv
// program_loader_if
// Bundles the host byte link (valid/ready) and the instruction-memory write
// port of the program loader, plus the CPU hold / status outputs.
//   rx_valid, rx_data   host -> loader byte stream
//   rx_ready            loader -> host, byte accepted when rx_valid & rx_ready
//   mem_we, mem_addr,
//   mem_wdata           loader -> instruction memory write port
//   cpu_init            processor hold, high = hold in reset
//   done, error         load status
// Modports: master = loader side, slave = host / memory / CPU side.
interface program_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_init;
    logic              done;
    logic              error;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_init, done, error
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_init, done, error
    );
endinterface

// File: rtl/program_loader.sv
// program_loader
// Receives a framed byte stream, assembles 16-bit instruction words and writes
// them sequentially into instruction memory starting at BASE_ADDR. The CPU is
// held via cpu_init until a complete image has been loaded.
// Frame: SYNC_BYTE, LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, [CHK]
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    program_loader_if.master (byte link, memory write port, status)
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum
// byte (XOR of LEN_HI, LEN_LO and all data bytes) before releasing the CPU.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | hunting for SYNC_BYTE, other bytes dropped
// LEN_HI  | waiting for word-count high byte
// LEN_LO  | waiting for word-count low byte, range check
// DATA_HI | waiting for instruction high byte
// DATA_LO | waiting for instruction low byte
// WRITE   | one-cycle memory write strobe, no byte accepted
// CHECK   | waiting for checksum byte (checksum build only)
// DONE    | image loaded, CPU released, SYNC_BYTE restarts a load
// ERROR   | frame rejected, CPU held, exit by reset only
module program_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256,
    parameter logic [7:0]        SYNC_BYTE = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    program_loader_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t      state;
    logic [7:0]  len_hi_q;
    logic [7:0]  data_hi_q;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [15:0] len_in;
    logic        rx_fire;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    // Ready is decoded from state so the host sees back-pressure in the same
    // cycle as the write strobe.
    assign bus.rx_ready = !reset && (state != WRITE) && (state != ERROR);
    assign rx_fire      = bus.rx_valid && bus.rx_ready;
    assign len_in       = {len_hi_q, bus.rx_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= 16'h0;
            bus.cpu_init  <= 1'b1;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
            len_hi_q      <= 8'h0;
            data_hi_q     <= 8'h0;
            len_q         <= 16'h0;
            count_q       <= 16'h0;
`ifdef LOADER_CHECKSUM_EN
            csum_q        <= 8'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire && bus.rx_data == SYNC_BYTE) begin
                        state <= LEN_HI;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= 8'h0;
`endif
                    end
                end
                LEN_HI: begin
                    if (rx_fire) begin
                        len_hi_q <= bus.rx_data;
                        state    <= LEN_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum_q   <= csum_q ^ bus.rx_data;
`endif
                    end
                end
                LEN_LO: begin
                    if (rx_fire) begin
                        len_q        <= len_in;
                        count_q      <= 16'h0;
                        bus.mem_addr <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                        csum_q       <= csum_q ^ bus.rx_data;
`endif
                        if (len_in > MAX_N) begin
                            state     <= ERROR;
                            bus.error <= 1'b1;
                        end else if (len_in == 16'h0) begin
`ifdef LOADER_CHECKSUM_EN
                            state        <= CHECK;
`else
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.cpu_init <= 1'b0;
`endif
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (rx_fire) begin
                        data_hi_q <= bus.rx_data;
                        state     <= DATA_LO;
`ifdef LOADER_CHECKSUM_EN
                        csum_q    <= csum_q ^ bus.rx_data;
`endif
                    end
                end
                DATA_LO: begin
                    if (rx_fire) begin
                        bus.mem_wdata <= {data_hi_q, bus.rx_data};
                        bus.mem_we    <= 1'b1;
                        state         <= WRITE;
`ifdef LOADER_CHECKSUM_EN
                        csum_q        <= csum_q ^ bus.rx_data;
`endif
                    end
                end
                WRITE: begin
                    // Address advances after the strobe; wraps at 2^ADDR_W.
                    bus.mem_we   <= 1'b0;
                    bus.mem_addr <= bus.mem_addr + ADDR_W'(1);
                    count_q      <= count_q + 16'd1;
                    if (count_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= CHECK;
`else
                        state        <= DONE;
                        bus.done     <= 1'b1;
                        bus.cpu_init <= 1'b0;
`endif
                    end else begin
                        state <= DATA_HI;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_fire) begin
                        if (bus.rx_data == csum_q) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.cpu_init <= 1'b0;
                        end else begin
                            state     <= ERROR;
                            bus.error <= 1'b1;
                        end
                    end
                end
`endif
                DONE: begin
                    if (rx_fire && bus.rx_data == SYNC_BYTE) begin
                        state        <= LEN_HI;
                        bus.cpu_init <= 1'b1;
                        bus.done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                        csum_q       <= 8'h0;
`endif
                    end
                end
                ERROR: begin
                    bus.cpu_init <= 1'b1;
                    bus.error    <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    typedef logic [7:0] bq_t[$];

    logic clk;
    logic reset;

    program_loader_if #(.ADDR_W(16)) bus ();

    program_loader #(
        .ADDR_W   (16),
        .BASE_ADDR(16'h0),
        .MAX_WORDS(256),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] wr_addr [0:1023];
    logic [15:0] wr_data [0:1023];
    int          wr_n = 0;
    int          viol_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and ready/strobe relationship, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset && bus.mem_we === 1'b1 && wr_n < 1024) begin
            wr_addr[wr_n] = bus.mem_addr;
            wr_data[wr_n] = bus.mem_wdata;
            wr_n = wr_n + 1;
        end
        if (!reset && bus.error !== 1'b1 && bus.rx_ready !== !bus.mem_we)
            viol_n = viol_n + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL send_byte_timeout: byte %02h, rx_ready %b, required 1", b, bus.rx_ready);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        if (gap) @(negedge clk);
    endtask

    task automatic send_frame(input bq_t q, input bit gap);
        foreach (q[i]) send_byte(q[i], gap);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.mem_we !== 1'b0)        begin n_fail++; $display("FAIL reset_mem_we: got %b, want 0", bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 16'h0)     begin n_fail++; $display("FAIL reset_mem_addr: got %h, want 0000", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 16'h0)    begin n_fail++; $display("FAIL reset_mem_wdata: got %h, want 0000", bus.mem_wdata); end
        n_cmp++; if (bus.cpu_init !== 1'b1)      begin n_fail++; $display("FAIL reset_cpu_init: got %b, want 1", bus.cpu_init); end
        n_cmp++; if (bus.done !== 1'b0)          begin n_fail++; $display("FAIL reset_done: got %b, want 0", bus.done); end
        n_cmp++; if (bus.error !== 1'b0)         begin n_fail++; $display("FAIL reset_error: got %b, want 0", bus.error); end
        n_cmp++; if (bus.rx_ready !== 1'b0)      begin n_fail++; $display("FAIL reset_rx_ready: got %b, want 0", bus.rx_ready); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rx_ready !== 1'b1)      begin n_fail++; $display("FAIL idle_rx_ready: got %b, want 1", bus.rx_ready); end
    endtask

    task automatic test_basic_load();
        int base;
        base = wr_n;
        send_frame('{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD}, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_before_chk: got %b, want 0", bus.done); end
        send_byte(8'h42, 1'b0);
        @(negedge clk);
`else
        @(negedge clk);
        n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL basic_last_we: got %b, want 1", bus.mem_we); end
        n_cmp++; if (bus.done !== 1'b0)   begin n_fail++; $display("FAIL basic_done_early: got %b, want 0", bus.done); end
        @(negedge clk);
`endif
        n_cmp++; if (bus.done !== 1'b1)     begin n_fail++; $display("FAIL basic_done: got %b, want 1", bus.done); end
        n_cmp++; if (bus.cpu_init !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_init: got %b, want 0", bus.cpu_init); end
        n_cmp++; if (wr_n - base !== 2)     begin n_fail++; $display("FAIL basic_write_count: got %0d, want 2", wr_n - base); end
        n_cmp++; if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'h1234)
            begin n_fail++; $display("FAIL basic_word0: got %h@%h, want 1234@0000", wr_data[base], wr_addr[base]); end
        n_cmp++; if (wr_addr[base+1] !== 16'h0001 || wr_data[base+1] !== 16'hABCD)
            begin n_fail++; $display("FAIL basic_word1: got %h@%h, want abcd@0001", wr_data[base+1], wr_addr[base+1]); end
    endtask

    task automatic test_leading_garbage();
        int base;
        apply_reset();
        base = wr_n;
        send_frame('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD}, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h72, 1'b0);
`endif
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_n - base !== 1) begin n_fail++; $display("FAIL garbage_write_count: got %0d, want 1", wr_n - base); end
        n_cmp++; if (wr_addr[base] !== 16'h0000 || wr_data[base] !== 16'hDEAD)
            begin n_fail++; $display("FAIL garbage_word0: got %h@%h, want dead@0000", wr_data[base], wr_addr[base]); end
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL garbage_done: got %b, want 1", bus.done); end
    endtask

    task automatic test_oversize();
        int base;
        apply_reset();
        base = wr_n;
        send_frame('{8'hA5, 8'h01, 8'h01}, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.error !== 1'b1)    begin n_fail++; $display("FAIL oversize_error: got %b, want 1", bus.error); end
        n_cmp++; if (bus.rx_ready !== 1'b0) begin n_fail++; $display("FAIL oversize_rx_ready: got %b, want 0", bus.rx_ready); end
        n_cmp++; if (bus.cpu_init !== 1'b1) begin n_fail++; $display("FAIL oversize_cpu_init: got %b, want 1", bus.cpu_init); end
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        repeat (8) @(negedge clk);
        bus.rx_valid = 1'b0;
        n_cmp++; if (bus.error !== 1'b1 || bus.done !== 1'b0)
            begin n_fail++; $display("FAIL oversize_sticky: got error=%b done=%b, want error=1 done=0", bus.error, bus.done); end
        n_cmp++; if (wr_n - base !== 0) begin n_fail++; $display("FAIL oversize_no_write: got %0d writes, want 0", wr_n - base); end
        apply_reset();
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL oversize_reset_clears: got %b, want 0", bus.error); end
    endtask

    task automatic test_zero_length();
        int base;
        apply_reset();
        base = wr_n;
        send_frame('{8'hA5, 8'h00, 8'h00}, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 1'b0);
`endif
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1 || bus.cpu_init !== 1'b0)
            begin n_fail++; $display("FAIL zero_len_done: got done=%b cpu_init=%b, want 1/0", bus.done, bus.cpu_init); end
        n_cmp++; if (wr_n - base !== 0) begin n_fail++; $display("FAIL zero_len_no_write: got %0d, want 0", wr_n - base); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_bad_checksum();
        int base;
        apply_reset();
        base = wr_n;
        send_frame('{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h00}, 1'b0);
        @(negedge clk);
        n_cmp++; if (wr_n - base !== 1 || wr_data[base] !== 16'h1122 || wr_addr[base] !== 16'h0)
            begin n_fail++; $display("FAIL badchk_write: got %0d writes first %h@%h, want 1 x 1122@0000", wr_n - base, wr_data[base], wr_addr[base]); end
        n_cmp++; if (bus.error !== 1'b1 || bus.cpu_init !== 1'b1 || bus.done !== 1'b0)
            begin n_fail++; $display("FAIL badchk_error: got error=%b cpu_init=%b done=%b, want 1/1/0", bus.error, bus.cpu_init, bus.done); end
        apply_reset();
        n_cmp++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL badchk_reset_clears: got %b, want 0", bus.error); end
    endtask
`endif

    task automatic test_back_to_back_gaps();
        int base;
        int vbase;
        logic [15:0] exp_d [0:2];
        exp_d[0] = 16'h0102; exp_d[1] = 16'h0304; exp_d[2] = 16'h0506;
        apply_reset();
        base  = wr_n;
        vbase = viol_n;
        send_frame('{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h04, 1'b1);
`endif
        repeat (3) @(negedge clk);
        n_cmp++; if (wr_n - base !== 3) begin n_fail++; $display("FAIL gaps_write_count: got %0d, want 3", wr_n - base); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (wr_addr[base+i] !== 16'(i) || wr_data[base+i] !== exp_d[i]) begin
                n_fail++;
                $display("FAIL gaps_word%0d: got %h@%h, want %h@%h", i, wr_data[base+i], wr_addr[base+i], exp_d[i], 16'(i));
            end
        end
        n_cmp++; if (viol_n - vbase !== 0) begin n_fail++; $display("FAIL gaps_ready_vs_write: got %0d mismatched cycles, want 0", viol_n - vbase); end
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got %b, want 1", bus.done); end
    endtask

    task automatic test_max_len();
        int base;
        logic [7:0] chk;
        apply_reset();
        base = wr_n;
        chk  = 8'h01;
        send_frame('{8'hA5, 8'h01, 8'h00}, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b0);
            send_byte(~8'(i), 1'b0);
            chk = chk ^ 8'(i) ^ ~8'(i);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(chk, 1'b0);
`endif
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_n - base !== 256) begin n_fail++; $display("FAIL max_write_count: got %0d, want 256", wr_n - base); end
        n_cmp++; if (wr_addr[base+255] !== 16'h00FF || wr_data[base+255] !== 16'hFF00)
            begin n_fail++; $display("FAIL max_last_word: got %h@%h, want ff00@00ff", wr_data[base+255], wr_addr[base+255]); end
        n_cmp++; if (bus.done !== 1'b1 || bus.error !== 1'b0)
            begin n_fail++; $display("FAIL max_done: got done=%b error=%b, want 1/0", bus.done, bus.error); end
    endtask

    task automatic test_reset_midframe();
        int base;
        apply_reset();
        send_frame('{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33}, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0)
            begin n_fail++; $display("FAIL midreset_mem: got we=%b addr=%h wdata=%h, want 0/0000/0000", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        n_cmp++; if (bus.cpu_init !== 1'b1 || bus.done !== 1'b0 || bus.error !== 1'b0 || bus.rx_ready !== 1'b0)
            begin n_fail++; $display("FAIL midreset_status: got cpu_init=%b done=%b error=%b ready=%b, want 1/0/0/0", bus.cpu_init, bus.done, bus.error, bus.rx_ready); end
        reset = 1'b0;
        base = wr_n;
        send_frame('{8'hA5, 8'h00, 8'h01, 8'h77, 8'h88}, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hFE, 1'b0);
`endif
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_n - base !== 1 || wr_addr[base] !== 16'h0 || wr_data[base] !== 16'h7788)
            begin n_fail++; $display("FAIL midreset_reload: got %0d writes first %h@%h, want 1 x 7788@0000", wr_n - base, wr_data[base], wr_addr[base]); end
        n_cmp++; if (bus.done !== 1'b1 || bus.cpu_init !== 1'b0)
            begin n_fail++; $display("FAIL midreset_done: got done=%b cpu_init=%b, want 1/0", bus.done, bus.cpu_init); end
        send_byte(8'h3C, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1 || bus.cpu_init !== 1'b0)
            begin n_fail++; $display("FAIL done_ignores_byte: got done=%b cpu_init=%b, want 1/0", bus.done, bus.cpu_init); end
        send_byte(8'hA5, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.cpu_init !== 1'b1 || bus.done !== 1'b0)
            begin n_fail++; $display("FAIL done_restart: got cpu_init=%b done=%b, want 1/0", bus.cpu_init, bus.done); end
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h0;
        test_reset();
        test_basic_load();
        test_leading_garbage();
        test_oversize();
        test_zero_length();
`ifdef LOADER_CHECKSUM_EN
        test_bad_checksum();
`endif
        test_back_to_back_gaps();
        test_max_len();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
